target_net_sync_ctrl: RTL and testbench
=======================================

Name: target_net_sync_ctrl

Overview:
- Schedules the target network's weight port and inference path.
- Counts training steps. Every UPDATE_PERIOD steps, or on a forced request, it copies all main-network weights into the target network, layer 1, then 2, then 3.
- Inference samples are held off at a sample boundary so a copy never overlaps an in-flight forward pass.
- Sits between the DQN top-level trainer, the main-net weight memory read port and the target network's data and weight inputs.

Parameters:
- DATA_WIDTH, 32, weight/data word width.
- LAYER_WIDTH, 2, layer code width (1=hidden1, 2=hidden2, 3=output).
- NUMBER_OF_INPUT_NODE, 2, input words per sample.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden-1 nodes.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden-2 nodes.
- NUMBER_OF_OUTPUT_NODE, 3, output nodes.
- ADDR_WIDTH, 11, weight address width; must hold the largest layer count (1056 by default).
- UPDATE_PERIOD, 100, training steps between syncs; range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i_train_step  in  1  one-cycle pulse per completed training step.
- i_force_sync  in  1  one-cycle pulse requesting an immediate sync.
- i_infer_valid  in  1  inference input word valid.
- i_infer_data  in  DATA_WIDTH  inference input word.
- o_infer_ready  out  1  controller accepts i_infer_data this cycle.
- o_data_valid  out  1  forwarded input word valid, to target net i_data_valid.
- o_data  out  DATA_WIDTH  forwarded input word.
- i_net_done  in  1  target net o_valid; one pulse per sample result.
- o_src_rd_en  out  1  main-net weight read strobe.
- o_src_layer  out  LAYER_WIDTH  main-net read layer.
- o_src_addr  out  ADDR_WIDTH  main-net read address.
- i_src_weight  in  DATA_WIDTH  main-net read data, valid exactly 1 cycle after o_src_rd_en.
- o_weight_valid  out  1  target net i_weight_valid.
- o_weight_layer  out  LAYER_WIDTH  target net i_weight_layer.
- o_weight  out  DATA_WIDTH  target net i_weight.
- o_sync_busy  out  1  high from leaving IDLE until DONE is exited.
- o_sync_done  out  1  one-cycle pulse when a copy completes.

Behaviour:
- Reset values:
  - All outputs 0, except o_infer_ready=1.
  - Step counter 0, pending flag 0, in-flight flag 0, sample word counter 0.
- Per-layer word counts include bias:
  - L1 = (IN+1)*H1 = 96.
  - L2 = (H1+1)*H2 = 1056.
  - L3 = (H2+1)*OUT = 99.
  - Addresses run 0..count-1 within each layer.
- Step counter:
  - Increments on i_train_step.
  - When it reaches UPDATE_PERIOD-1 together with a step, it wraps to 0 and sets pending.
  - It keeps counting during a copy.
- Pending flag:
  - Set by the counter wrap or by i_force_sync; both in one cycle still give a single pending.
  - A new request while already pending or copying collapses into one further sync after the current copy.
- Inference path:
  - Accept a word when i_infer_valid && o_infer_ready. It is forwarded registered: o_data_valid/o_data appear 1 cycle later.
  - Sample word counter wraps at NUMBER_OF_INPUT_NODE. The first accepted word sets in-flight; i_net_done clears it.
  - o_infer_ready=0 when (pending && sample word counter==0) or in any copy state. A sample is therefore never split.
- States:
  - IDLE: if pending, go to DRAIN.
  - DRAIN: wait until in-flight==0 and no partial sample is outstanding, then go to COPY with layer=1, addr=0, and clear pending.
  - COPY:
    - Issue o_src_rd_en every cycle with o_src_layer=layer, o_src_addr=addr.
    - At addr==count(layer)-1: if layer<3, advance to the next layer with addr=0; else go to FLUSH.
  - FLUSH: wait 2 cycles for the pipeline to empty, then go to DONE.
  - DONE: pulse o_sync_done, then go to IDLE. If pending was set meanwhile, re-enter DRAIN from IDLE on the next cycle.
- Copy pipeline:
  - Read issued at cycle t; i_src_weight is registered at t+1.
  - o_weight_valid/o_weight_layer/o_weight are presented at t+2.
  - One weight per cycle, no bubbles.
  - A full copy takes 1251 write cycles.
- i_net_done while not in-flight is ignored.
- rst mid-copy aborts immediately; all flags clear and the target weights are left partial. The trainer must reissue i_force_sync.

Optional Feature:
- Macro: SYNC_STATS_EN.
- Defined:
  - Adds output o_sync_count[15:0], incremented on each o_sync_done and saturating at 16'hFFFF; reset 0.
  - Adds output o_sync_stall, high in DRAIN while in-flight is set.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package dqn_pkg holds:
  - The layer code constants LAYER_H1=1, LAYER_H2=2, LAYER_OUT=3.
  - The state enum.
  - A function returning the per-layer weight count from the node parameters.
- One sub-module, weight_copy_pipe: the 2-stage read-to-write register pipeline carrying the valid, layer and data.

Test Plan:
- UPDATE_PERIOD=4, four i_train_step pulses, no inference:
  - o_sync_busy rises after the 4th pulse.
  - Exactly 96 writes on layer 1, then 1056 on layer 2, then 99 on layer 3.
  - o_weight equals the source memory pattern addr^layer; one o_sync_done pulse.
- Sample streaming, i_force_sync after word 1 of 2:
  - Word 2 is still accepted; o_infer_ready then drops.
  - No o_weight_valid until i_net_done; after that the copy starts in DRAIN→COPY.
- i_force_sync and counter wrap in the same cycle:
  - Exactly one copy (1251 writes) and one o_sync_done.
- i_force_sync during COPY:
  - A second full copy follows immediately after DONE; o_sync_done is pulsed twice in total.
- rst asserted at write 500:
  - Next cycle all outputs are at reset values and o_infer_ready=1.
  - No further writes until a new request.
- SYNC_STATS_EN defined, 3 forced syncs: o_sync_count=3.

Source files
------------

// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN target-network sync controller.
// Holds the layer codes, the sync FSM state encoding and the per-layer
// weight count helper (bias words included).
package dqn_pkg;

  localparam int unsigned LAYER_H1  = 1;
  localparam int unsigned LAYER_H2  = 2;
  localparam int unsigned LAYER_OUT = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_COPY,
    S_FLUSH,
    S_DONE
  } sync_state_e;

  // Words per layer including one bias row: (fan_in + 1) * fan_out.
  function automatic int unsigned layer_word_count(
    input int unsigned layer,
    input int unsigned n_in,
    input int unsigned n_h1,
    input int unsigned n_h2,
    input int unsigned n_out
  );
    case (layer)
      LAYER_H1:  return (n_in + 1) * n_h1;
      LAYER_H2:  return (n_h1 + 1) * n_h2;
      LAYER_OUT: return (n_h2 + 1) * n_out;
      default:   return 0;
    endcase
  endfunction

endpackage

// File: rtl/weight_copy_pipe.sv
// Two-stage read-to-write pipeline for the weight copy.
// Stage 0 delays the read strobe/layer to line up with the source read data,
// stage 1 registers the returned word together with its valid and layer.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_rd_en      read strobe issued to the source memory
//   i_rd_layer   layer of the issued read
//   i_rd_data    source data, valid one cycle after i_rd_en
//   o_valid      write strobe to target net (two cycles after i_rd_en)
//   o_layer      write layer
//   o_data       write data
module weight_copy_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LAYER_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rd_en,
  input  logic [LAYER_WIDTH-1:0] i_rd_layer,
  input  logic [DATA_WIDTH-1:0]  i_rd_data,
  output logic                   o_valid,
  output logic [LAYER_WIDTH-1:0] o_layer,
  output logic [DATA_WIDTH-1:0]  o_data
);

  logic                   s0_valid;
  logic [LAYER_WIDTH-1:0] s0_layer;

  // Stage 0: strobe/layer wait for the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_layer <= '0;
    end else begin
      s0_valid <= i_rd_en;
      s0_layer <= i_rd_en ? i_rd_layer : '0;
    end
  end

  // Stage 1: capture the returned word alongside its strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_layer <= '0;
      o_data  <= '0;
    end else begin
      o_valid <= s0_valid;
      o_layer <= s0_layer;
      o_data  <= s0_valid ? i_rd_data : '0;
    end
  end

endmodule

// File: rtl/target_net_sync_ctrl.sv
// Target-network sync controller for the DQN trainer.
// Counts training steps and, every UPDATE_PERIOD steps or on a forced
// request, copies all main-net weights (layer 1, 2, 3) into the target net.
// Inference input is held off at sample boundaries so a copy never overlaps
// an in-flight forward pass.
// Optional macro SYNC_STATS_EN adds o_sync_count and o_sync_stall.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_train_step, i_force_sync      step pulse, immediate sync request
//   i_infer_valid/i_infer_data      inference word in; o_infer_ready accepts
//   o_data_valid/o_data             registered forward to target net
//   i_net_done                      target net result pulse (ends a sample)
//   o_src_rd_en/layer/addr          main-net weight read port
//   i_src_weight                    main-net read data (1-cycle latency)
//   o_weight_valid/layer/o_weight   target net weight write port
//   o_sync_busy, o_sync_done        copy status
module target_net_sync_ctrl
  import dqn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                    = 32,
  parameter int unsigned LAYER_WIDTH                   = 2,
  parameter int unsigned NUMBER_OF_INPUT_NODE          = 2,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int unsigned NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int unsigned NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int unsigned ADDR_WIDTH                    = 11,
  parameter int unsigned UPDATE_PERIOD                 = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_train_step,
  input  logic                   i_force_sync,
  input  logic                   i_infer_valid,
  input  logic [DATA_WIDTH-1:0]  i_infer_data,
  output logic                   o_infer_ready,
  output logic                   o_data_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  input  logic                   i_net_done,
  output logic                   o_src_rd_en,
  output logic [LAYER_WIDTH-1:0] o_src_layer,
  output logic [ADDR_WIDTH-1:0]  o_src_addr,
  input  logic [DATA_WIDTH-1:0]  i_src_weight,
  output logic                   o_weight_valid,
  output logic [LAYER_WIDTH-1:0] o_weight_layer,
  output logic [DATA_WIDTH-1:0]  o_weight,
  output logic                   o_sync_busy,
  output logic                   o_sync_done
`ifdef SYNC_STATS_EN
  ,
  output logic [15:0]            o_sync_count,
  output logic                   o_sync_stall
`endif
);

  localparam int unsigned STEP_WIDTH = 16;
  localparam int unsigned WCNT_WIDTH =
    (NUMBER_OF_INPUT_NODE > 1) ? $clog2(NUMBER_OF_INPUT_NODE) : 1;

  sync_state_e state_q, state_d;

  logic [STEP_WIDTH-1:0]  step_cnt_q, step_cnt_d;
  logic                   pending_q, pending_d;
  logic                   inflight_q, inflight_d;
  logic [WCNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic                   flush_q, flush_d;
  logic                   rd_en_q, rd_en_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   ready_q, ready_d;
  logic                   dvalid_q, dvalid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   accept;
  logic                   step_wrap;
  logic                   drain_ok;
  logic [ADDR_WIDTH-1:0]  cur_last;
  logic                   layer_end;

  // Request bookkeeping: step counter, pending flag, sample tracking.
  always_comb begin
    accept     = i_infer_valid && ready_q;
    step_wrap  = 1'b0;
    step_cnt_d = step_cnt_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    wcnt_d     = wcnt_q;

    if (i_train_step) begin
      if (step_cnt_q == STEP_WIDTH'(UPDATE_PERIOD - 1)) begin
        step_cnt_d = '0;
        step_wrap  = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + STEP_WIDTH'(1);
      end
    end

    // Clear on DRAIN exit, but a request in the same cycle still wins.
    if (state_q == S_DRAIN && drain_ok) pending_d = 1'b0;
    if (step_wrap || i_force_sync)      pending_d = 1'b1;

    if (i_net_done)            inflight_d = 1'b0;
    if (accept && wcnt_q == '0) inflight_d = 1'b1;

    if (accept) begin
      if (wcnt_q == WCNT_WIDTH'(NUMBER_OF_INPUT_NODE - 1)) wcnt_d = '0;
      else                                                 wcnt_d = wcnt_q + WCNT_WIDTH'(1);
    end
  end

  // Last address of the layer currently being copied.
  always_comb begin
    cur_last = ADDR_WIDTH'(layer_word_count(32'(layer_q),
                                            NUMBER_OF_INPUT_NODE,
                                            NUMBER_OF_HIDDEN_NODE_LAYER_1,
                                            NUMBER_OF_HIDDEN_NODE_LAYER_2,
                                            NUMBER_OF_OUTPUT_NODE) - 1);
    layer_end = (addr_q == cur_last);
    drain_ok  = !inflight_q && (wcnt_q == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pending_q) state_d = S_DRAIN;
      S_DRAIN: if (drain_ok)  state_d = S_COPY;
      S_COPY:  if (layer_end && layer_q == LAYER_WIDTH'(LAYER_OUT)) state_d = S_FLUSH;
      S_FLUSH: if (flush_q)   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; all of them land in registers below.
  always_comb begin
    rd_en_d  = (state_d == S_COPY);
    layer_d  = '0;
    addr_d   = '0;
    flush_d  = (state_q == S_FLUSH) ? !flush_q : 1'b0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    dvalid_d = accept;
    data_d   = accept ? i_infer_data : '0;
    ready_d  = !((pending_d && wcnt_d == '0) ||
                 state_d == S_COPY || state_d == S_FLUSH || state_d == S_DONE);

    if (state_d == S_COPY) begin
      if (state_q != S_COPY) begin
        layer_d = LAYER_WIDTH'(LAYER_H1);
        addr_d  = '0;
      end else if (layer_end) begin
        layer_d = layer_q + LAYER_WIDTH'(1);
        addr_d  = '0;
      end else begin
        layer_d = layer_q;
        addr_d  = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q <= '0;
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
      wcnt_q     <= '0;
      flush_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      layer_q    <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      dvalid_q   <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      wcnt_q     <= wcnt_d;
      flush_q    <= flush_d;
      rd_en_q    <= rd_en_d;
      layer_q    <= layer_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      dvalid_q   <= dvalid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_infer_ready = ready_q;
  assign o_data_valid  = dvalid_q;
  assign o_data        = data_q;
  assign o_src_rd_en   = rd_en_q;
  assign o_src_layer   = layer_q;
  assign o_src_addr    = addr_q;
  assign o_sync_busy   = busy_q;
  assign o_sync_done   = done_q;

  weight_copy_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LAYER_WIDTH (LAYER_WIDTH)
  ) u_copy_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_rd_en    (rd_en_q),
    .i_rd_layer (layer_q),
    .i_rd_data  (i_src_weight),
    .o_valid    (o_weight_valid),
    .o_layer    (o_weight_layer),
    .o_data     (o_weight)
  );

`ifdef SYNC_STATS_EN
  logic [15:0] sync_count_q;
  logic        stall_q;

  // Completed-sync counter (saturating) and drain-stall indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_count_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      if (done_q && sync_count_q != 16'hFFFF) sync_count_q <= sync_count_q + 16'd1;
      stall_q <= (state_d == S_DRAIN) && inflight_d;
    end
  end

  assign o_sync_count = sync_count_q;
  assign o_sync_stall = stall_q;
`endif

endmodule

// File: tb/tb_target_net_sync_ctrl.sv
// Directed self-checking bench for target_net_sync_ctrl (UPDATE_PERIOD=4).
// A registered source-memory model returns addr^layer; a write monitor
// checks every target write against the expected layer/address sequence.
// Optional macro SYNC_STATS_EN enables the statistics port checks.
module tb_target_net_sync_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 2;
  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_train_step;
  logic          i_force_sync;
  logic          i_infer_valid;
  logic [DW-1:0] i_infer_data;
  logic          o_infer_ready;
  logic          o_data_valid;
  logic [DW-1:0] o_data;
  logic          i_net_done;
  logic          o_src_rd_en;
  logic [LW-1:0] o_src_layer;
  logic [AW-1:0] o_src_addr;
  logic [DW-1:0] i_src_weight = '0;
  logic          o_weight_valid;
  logic [LW-1:0] o_weight_layer;
  logic [DW-1:0] o_weight;
  logic          o_sync_busy;
  logic          o_sync_done;
`ifdef SYNC_STATS_EN
  logic [15:0]   o_sync_count;
  logic          o_sync_stall;
`endif

  int checks   = 0;
  int failures = 0;

  // Monitor state (written only by the monitor process).
  int wr_total  = 0;
  int wr_cnt[4] = '{0, 0, 0, 0};
  int done_cnt  = 0;
  int data_errs = 0;
  int mon_layer = 1;
  int mon_addr  = 0;

  always #5 clk = ~clk;

  target_net_sync_ctrl #(.UPDATE_PERIOD(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_train_step   (i_train_step),
    .i_force_sync   (i_force_sync),
    .i_infer_valid  (i_infer_valid),
    .i_infer_data   (i_infer_data),
    .o_infer_ready  (o_infer_ready),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .i_net_done     (i_net_done),
    .o_src_rd_en    (o_src_rd_en),
    .o_src_layer    (o_src_layer),
    .o_src_addr     (o_src_addr),
    .i_src_weight   (i_src_weight),
    .o_weight_valid (o_weight_valid),
    .o_weight_layer (o_weight_layer),
    .o_weight       (o_weight),
    .o_sync_busy    (o_sync_busy),
    .o_sync_done    (o_sync_done)
`ifdef SYNC_STATS_EN
    ,
    .o_sync_count   (o_sync_count),
    .o_sync_stall   (o_sync_stall)
`endif
  );

  // Main-net weight memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    i_src_weight <= o_src_rd_en ? (32'(o_src_addr) ^ 32'(o_src_layer)) : '0;
  end

  function automatic int exp_count(input int layer);
    case (layer)
      1:       return 96;
      2:       return 1056;
      default: return 99;
    endcase
  endfunction

  // Write monitor: expected sequence is layer 1..3, addr 0..count-1.
  always @(negedge clk) begin
    if (rst) begin
      mon_layer = 1;
      mon_addr  = 0;
    end else if (o_weight_valid) begin
      if (32'(o_weight_layer) != 32'(mon_layer) ||
          o_weight != (32'(mon_addr) ^ 32'(mon_layer)))
        data_errs++;
      wr_cnt[mon_layer]++;
      wr_total++;
      mon_addr++;
      if (mon_addr == exp_count(mon_layer)) begin
        mon_addr  = 0;
        mon_layer = (mon_layer == 3) ? 1 : mon_layer + 1;
      end
    end
    if (!rst && o_sync_done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_force();
    i_force_sync = 1'b1;
    tick(1);
    i_force_sync = 1'b0;
  endtask

  task automatic pulse_step();
    i_train_step = 1'b1;
    tick(1);
    i_train_step = 1'b0;
    tick(2);
  endtask

  task automatic wait_busy(input string tag, input int limit);
    int n = 0;
    while (!o_sync_busy && n < limit) begin
      tick(1);
      n++;
    end
    if (!o_sync_busy) check_eq(tag, 0, 1);
  endtask

  // Wait until busy has stayed low for 10 cycles.
  task automatic wait_idle(input string tag, input int limit);
    int quiet = 0;
    int n = 0;
    while (quiet < 10 && n < limit) begin
      tick(1);
      n++;
      quiet = o_sync_busy ? 0 : quiet + 1;
    end
    if (quiet < 10) check_eq(tag, 0, 1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int limit);
    int n = 0;
    while (wr_total < target && n < limit) begin
      tick(1);
      n++;
    end
    if (wr_total < target) check_eq(tag, 64'(wr_total), 64'(target));
  endtask

  task automatic full_sync(input string tag);
    int base = wr_total;
    int d0   = done_cnt;
    pulse_force();
    wait_busy({tag, "_start_timeout"}, 20);
    wait_idle({tag, "_idle_timeout"}, 3000);
    check_eq({tag, "_writes"}, 64'(wr_total - base), 1251);
    check_eq({tag, "_done"}, 64'(done_cnt - d0), 1);
  endtask

  initial begin
    int base, d0, b1, b2, b3, snap;
    rst           = 1'b1;
    i_train_step  = 1'b0;
    i_force_sync  = 1'b0;
    i_infer_valid = 1'b0;
    i_infer_data  = '0;
    i_net_done    = 1'b0;
    tick(3);

    // Reset values.
    check_eq("rst_ready", 64'(o_infer_ready), 1);
    check_eq("rst_data_valid", 64'(o_data_valid), 0);
    check_eq("rst_rd_en", 64'(o_src_rd_en), 0);
    check_eq("rst_weight_valid", 64'(o_weight_valid), 0);
    check_eq("rst_busy", 64'(o_sync_busy), 0);
    check_eq("rst_done", 64'(o_sync_done), 0);
    rst = 1'b0;
    tick(2);

    // Periodic sync after 4 training steps.
    base = wr_total; d0 = done_cnt;
    b1 = wr_cnt[1]; b2 = wr_cnt[2]; b3 = wr_cnt[3];
    repeat (3) pulse_step();
    check_eq("busy_before_wrap", 64'(o_sync_busy), 0);
    i_train_step = 1'b1;
    tick(1);
    i_train_step = 1'b0;
    tick(1);
    check_eq("busy_after_wrap", 64'(o_sync_busy), 1);
    wait_idle("period_idle_timeout", 3000);
    check_eq("period_l1_writes", 64'(wr_cnt[1] - b1), 96);
    check_eq("period_l2_writes", 64'(wr_cnt[2] - b2), 1056);
    check_eq("period_l3_writes", 64'(wr_cnt[3] - b3), 99);
    check_eq("period_total", 64'(wr_total - base), 1251);
    check_eq("period_done", 64'(done_cnt - d0), 1);
    check_eq("period_data_errs", 64'(data_errs), 0);

    // Forced sync mid-sample: second word still accepted, copy waits for net_done.
    base = wr_total; d0 = done_cnt;
    i_infer_valid = 1'b1;
    i_infer_data  = 32'hA5A5_0001;
    tick(1);
    check_eq("fwd_valid_w1", 64'(o_data_valid), 1);
    check_eq("fwd_data_w1", 64'(o_data), 64'h A5A5_0001);
    i_infer_valid = 1'b0;
    i_force_sync  = 1'b1;
    tick(1);
    i_force_sync  = 1'b0;
    check_eq("ready_mid_sample", 64'(o_infer_ready), 1);
    i_infer_valid = 1'b1;
    i_infer_data  = 32'h5A5A_0002;
    tick(1);
    i_infer_valid = 1'b0;
    check_eq("ready_after_sample", 64'(o_infer_ready), 0);
    check_eq("fwd_data_w2", 64'(o_data), 64'h5A5A_0002);
    tick(20);
    check_eq("drain_no_writes", 64'(wr_total - base), 0);
    check_eq("drain_busy", 64'(o_sync_busy), 1);
`ifdef SYNC_STATS_EN
    check_eq("drain_stall", 64'(o_sync_stall), 1);
`endif
    i_net_done = 1'b1;
    tick(1);
    i_net_done = 1'b0;
    wait_idle("drain_idle_timeout", 3000);
    check_eq("drain_total", 64'(wr_total - base), 1251);
    check_eq("drain_done", 64'(done_cnt - d0), 1);
    check_eq("ready_after_copy", 64'(o_infer_ready), 1);

    // Counter wrap and force in the same cycle collapse into one copy.
    base = wr_total; d0 = done_cnt;
    repeat (3) pulse_step();
    i_train_step = 1'b1;
    i_force_sync = 1'b1;
    tick(1);
    i_train_step = 1'b0;
    i_force_sync = 1'b0;
    wait_busy("both_start_timeout", 20);
    wait_idle("both_idle_timeout", 3000);
    check_eq("both_total", 64'(wr_total - base), 1251);
    check_eq("both_done", 64'(done_cnt - d0), 1);

    // Force during COPY queues exactly one more full copy.
    base = wr_total; d0 = done_cnt;
    pulse_force();
    wait_writes("mid_copy_timeout", base + 300, 2000);
    pulse_force();
    wait_idle("double_idle_timeout", 6000);
    check_eq("double_total", 64'(wr_total - base), 2502);
    check_eq("double_done", 64'(done_cnt - d0), 2);

    // Reset mid-copy aborts at once and stays quiet.
    base = wr_total;
    pulse_force();
    wait_writes("abort_timeout", base + 500, 2000);
    rst = 1'b1;
    tick(1);
    snap = wr_total;
    check_eq("abort_weight_valid", 64'(o_weight_valid), 0);
    check_eq("abort_rd_en", 64'(o_src_rd_en), 0);
    check_eq("abort_busy", 64'(o_sync_busy), 0);
    check_eq("abort_ready", 64'(o_infer_ready), 1);
    check_eq("abort_addr", 64'(o_src_addr), 0);
    check_eq("abort_weight", 64'(o_weight), 0);
    rst = 1'b0;
    tick(50);
    check_eq("abort_no_writes", 64'(wr_total - snap), 0);
    check_eq("abort_still_idle", 64'(o_sync_busy), 0);

    // Recovery: three forced syncs after reset.
    full_sync("recover1");
    full_sync("recover2");
    full_sync("recover3");
`ifdef SYNC_STATS_EN
    check_eq("sync_count", 64'(o_sync_count), 3);
`endif
    check_eq("final_data_errs", 64'(data_errs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
